vga_sync_generator: RTL and testbench

Generates VGA raster timing in the pixel clock domain: horizontal/vertical counters, sync pulses, and the active-area `draw` enable. It drives `hsinc`, `vsinc` and `draw` into the on-screen renderers, such as the clock-digit printer. It also exports pixel coordinates and frame/line markers. Default timing is 640x480 @ 60 Hz with a 25.175 MHz pixel clock.

---
 rtl/vga_sync_if.sv | 24 ++
 rtl/vga_sync_generator.sv | 146 ++++++++++++++
 tb/tb_vga_sync_generator.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_if.sv
// Purpose : VGA raster timing bundle from the sync generator to on-screen renderers.
// Latency : n/a (wiring only); all members are registered by the generator.
// Backpr. : none; the raster free-runs and consumers must keep pace with the pixel clock.
// Members : hsinc/vsinc sync levels, draw visible-area enable, h_count/v_count pixel
//           coordinates, line_start/frame_start one-cycle markers at column 0 / pixel (0,0).
interface vga_sync_if #(
  parameter int CNT_W = 10
);
  logic             hsinc;
  logic             vsinc;
  logic             draw;
  logic [CNT_W-1:0] h_count;
  logic [CNT_W-1:0] v_count;
  logic             line_start;
  logic             frame_start;

  modport master (
    output hsinc, vsinc, draw, h_count, v_count, line_start, frame_start
  );

  modport slave (
    input  hsinc, vsinc, draw, h_count, v_count, line_start, frame_start
  );
endinterface

// File: rtl/vga_sync_generator.sv
// Purpose : VGA raster timing (h/v counters, sync pulses, draw enable, line/frame markers).
// Latency : every output is registered and aligned with the h_count/v_count it describes.
// Backpr. : none; free-running at one pixel per pixelclock.
// Ports   : pixelclock (rising edge), reset (synchronous, active-high),
//           o_sync (vga_sync_if.master): hsinc, vsinc, draw, h_count, v_count,
//           line_start, frame_start.
module vga_sync_generator #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CNT_W    = 10
) (
  input  logic       pixelclock,
  input  logic       reset,
  vga_sync_if.master o_sync
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Last count of each region; a state leaves its region on the cycle its end count is shown.
  localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] H_FP_END  = CNT_W'(H_ACTIVE + H_FRONT - 1);
  localparam logic [CNT_W-1:0] H_SY_END  = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_FP_END  = CNT_W'(V_ACTIVE + V_FRONT - 1);
  localparam logic [CNT_W-1:0] V_SY_END  = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);

  // Configuration errors are caught at elaboration; nothing is checked at run time.
  if ((H_TOTAL > (1 << CNT_W)) || (V_TOTAL > (1 << CNT_W))) begin : g_cnt_w_too_narrow
    $fatal(1, "vga_sync_generator: CNT_W cannot hold H_TOTAL-1 / V_TOTAL-1");
  end
  if ((H_ACTIVE < 1) || (H_FRONT < 1) || (H_SYNC < 1) || (H_BACK < 1) ||
      (V_ACTIVE < 1) || (V_FRONT < 1) || (V_SYNC < 1) || (V_BACK < 1)) begin : g_empty_region
    $fatal(1, "vga_sync_generator: every timing region must be at least one unit long");
  end

  typedef enum logic [1:0] {H_ACT, H_FP, H_SY, H_BP} h_state_t;
  typedef enum logic [1:0] {V_ACT, V_FP, V_SY, V_BP} v_state_t;

  h_state_t         r_h_state;
  v_state_t         r_v_state;
  logic [CNT_W-1:0] r_h_count;
  logic [CNT_W-1:0] r_v_count;
  // Set by reset: the first cycle after release shows pixel (0,0) again, now with
  // draw/line_start/frame_start decoded, so the counters hold for that one edge.
  logic             r_hold;
  logic             r_hsinc;
  logic             r_vsinc;
  logic             r_draw;
  logic             r_line_start;
  logic             r_frame_start;

  h_state_t         w_h_state_nx;
  v_state_t         w_v_state_nx;
  logic [CNT_W-1:0] w_h_count_nx;
  logic [CNT_W-1:0] w_v_count_nx;
  logic             w_h_wrap;
  logic             w_v_wrap;

  // Next raster position and region. Outputs are decoded from these next values so
  // that, once registered, they line up with the counters they describe.
  always_comb begin
    w_h_wrap     = (r_h_count == H_LAST);
    w_v_wrap     = (r_v_count == V_LAST);
    w_h_count_nx = '0;
    w_v_count_nx = '0;
    w_h_state_nx = H_ACT;
    w_v_state_nx = V_ACT;
    if (!r_hold) begin
      w_h_count_nx = w_h_wrap ? '0 : r_h_count + CNT_W'(1);
      w_v_count_nx = r_v_count;
      w_v_state_nx = r_v_state;
      // The wrap forces the active state, so a state out of step with the counter
      // can never persist past the end of a line (or frame, vertically).
      if (w_h_wrap) begin
        w_h_state_nx = H_ACT;
      end else begin
        w_h_state_nx = r_h_state;
        case (r_h_state)
          H_ACT: if (r_h_count == H_ACT_END) w_h_state_nx = H_FP;
          H_FP:  if (r_h_count == H_FP_END)  w_h_state_nx = H_SY;
          H_SY:  if (r_h_count == H_SY_END)  w_h_state_nx = H_BP;
          H_BP:  w_h_state_nx = H_BP;
        endcase
      end
      // Vertical position only moves at the end of a line, so vsinc edges land on h_count==0.
      if (w_h_wrap) begin
        w_v_count_nx = w_v_wrap ? '0 : r_v_count + CNT_W'(1);
        if (w_v_wrap) begin
          w_v_state_nx = V_ACT;
        end else begin
          case (r_v_state)
            V_ACT: if (r_v_count == V_ACT_END) w_v_state_nx = V_FP;
            V_FP:  if (r_v_count == V_FP_END)  w_v_state_nx = V_SY;
            V_SY:  if (r_v_count == V_SY_END)  w_v_state_nx = V_BP;
            V_BP:  w_v_state_nx = V_BP;
          endcase
        end
      end
    end
  end

  always_ff @(posedge pixelclock) begin
    if (reset) begin
      r_hold        <= 1'b1;
      r_h_count     <= '0;
      r_v_count     <= '0;
      r_h_state     <= H_ACT;
      r_v_state     <= V_ACT;
      r_hsinc       <= ~SYNC_POL;
      r_vsinc       <= ~SYNC_POL;
      r_draw        <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hold        <= 1'b0;
      r_h_count     <= w_h_count_nx;
      r_v_count     <= w_v_count_nx;
      r_h_state     <= w_h_state_nx;
      r_v_state     <= w_v_state_nx;
      r_hsinc       <= (w_h_state_nx == H_SY) ? SYNC_POL : ~SYNC_POL;
      r_vsinc       <= (w_v_state_nx == V_SY) ? SYNC_POL : ~SYNC_POL;
      r_draw        <= (w_h_state_nx == H_ACT) && (w_v_state_nx == V_ACT);
      r_line_start  <= (w_h_count_nx == '0);
      r_frame_start <= (w_h_count_nx == '0) && (w_v_count_nx == '0);
    end
  end

  assign o_sync.hsinc       = r_hsinc;
  assign o_sync.vsinc       = r_vsinc;
  assign o_sync.draw        = r_draw;
  assign o_sync.h_count     = r_h_count;
  assign o_sync.v_count     = r_v_count;
  assign o_sync.line_start  = r_line_start;
  assign o_sync.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Purpose : self-checking bench for vga_sync_generator with three timing configurations:
//           A = default 640x480, B = tiny 8x6 raster with active-high sync,
//           C = short 16-pixel lines with the default 525-line vertical timing.
// Ports   : none; drives pixelclock and one reset per instance.
module tb_vga_sync_generator;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       draw;
    logic       ls;
    logic       fs;
  } obs_t;

  typedef struct {
    bit   rst;
    int   n;
    obs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  vga_sync_if #(.CNT_W(10)) sa ();
  vga_sync_if #(.CNT_W(10)) sb ();
  vga_sync_if #(.CNT_W(10)) sc ();

  vga_sync_generator dut_a (
    .pixelclock (clk),
    .reset      (rst_a),
    .o_sync     (sa)
  );

  vga_sync_generator #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_POL(1'b1), .CNT_W(10)
  ) dut_b (
    .pixelclock (clk),
    .reset      (rst_b),
    .o_sync     (sb)
  );

  vga_sync_generator #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACTIVE(480), .V_FRONT(10), .V_SYNC(2), .V_BACK(33),
    .SYNC_POL(1'b0), .CNT_W(10)
  ) dut_c (
    .pixelclock (clk),
    .reset      (rst_c),
    .o_sync     (sc)
  );

  obs_t oa, ob, oc;
  assign oa = {sa.h_count, sa.v_count, sa.hsinc, sa.vsinc, sa.draw, sa.line_start, sa.frame_start};
  assign ob = {sb.h_count, sb.v_count, sb.hsinc, sb.vsinc, sb.draw, sb.line_start, sb.frame_start};
  assign oc = {sc.h_count, sc.v_count, sc.hsinc, sc.vsinc, sc.draw, sc.line_start, sc.frame_start};

  function automatic obs_t mk(int h, int v, bit hs, bit vs, bit d, bit ls, bit fs);
    obs_t o;
    o.h = 10'(h); o.v = 10'(v);
    o.hs = hs; o.vs = vs; o.draw = d; o.ls = ls; o.fs = fs;
    return o;
  endfunction

  // Reference decode: what a pixel at (h,v) must show, straight from the region widths.
  function automatic obs_t model(int h, int v, int ha, int hf, int hw,
                                 int va, int vf, int vw, bit pol);
    obs_t o;
    o.h    = 10'(h);
    o.v    = 10'(v);
    o.hs   = (h >= ha + hf && h < ha + hf + hw) ? pol : ~pol;
    o.vs   = (v >= va + vf && v < va + vf + vw) ? pol : ~pol;
    o.draw = (h < ha) && (v < va);
    o.ls   = (h == 0);
    o.fs   = (h == 0) && (v == 0);
    return o;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_obs(input string nm, input obs_t act, input obs_t exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got h=%0d v=%0d hs=%b vs=%b draw=%b ls=%b fs=%b, expected h=%0d v=%0d hs=%b vs=%b draw=%b ls=%b fs=%b",
               nm, act.h, act.v, act.hs, act.vs, act.draw, act.ls, act.fs,
               exp.h, exp.v, exp.hs, exp.vs, exp.draw, exp.ls, exp.fs);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  vec_t va_tbl [11];
  logic [4:0] sig1 [8400];

  initial begin
    int mh, mv, mism, n_draw, n_hs, n_ls, n_vs_low, vs_bad, late_draw, n_hs_pulse, n_fs;
    logic prev_vs, prev_hs;
    obs_t ex;

    // ---------------- A: default timing, one line, table-driven ----------------
    va_tbl[0]  = '{1'b1, 5,   mk(0,   0, 1, 1, 0, 0, 0)};  // held in reset
    va_tbl[1]  = '{1'b0, 1,   mk(0,   0, 1, 1, 1, 1, 1)};  // first cycle after release
    va_tbl[2]  = '{1'b0, 1,   mk(1,   0, 1, 1, 1, 0, 0)};
    va_tbl[3]  = '{1'b0, 638, mk(639, 0, 1, 1, 1, 0, 0)};  // last visible pixel
    va_tbl[4]  = '{1'b0, 1,   mk(640, 0, 1, 1, 0, 0, 0)};  // front porch
    va_tbl[5]  = '{1'b0, 15,  mk(655, 0, 1, 1, 0, 0, 0)};
    va_tbl[6]  = '{1'b0, 1,   mk(656, 0, 0, 1, 0, 0, 0)};  // hsync starts
    va_tbl[7]  = '{1'b0, 95,  mk(751, 0, 0, 1, 0, 0, 0)};
    va_tbl[8]  = '{1'b0, 1,   mk(752, 0, 1, 1, 0, 0, 0)};  // back porch
    va_tbl[9]  = '{1'b0, 47,  mk(799, 0, 1, 1, 0, 0, 0)};
    va_tbl[10] = '{1'b0, 1,   mk(0,   1, 1, 1, 1, 1, 0)};  // line wrap

    for (int i = 0; i < 11; i++) begin
      rst_a = va_tbl[i].rst;
      step(va_tbl[i].n);
      check_obs($sformatf("a_vec%0d", i), oa, va_tbl[i].exp);
    end

    n_draw = 0; n_hs = 0; n_ls = 0;
    for (int i = 0; i < 800; i++) begin
      if (oa.draw) n_draw++;
      if (!oa.hs)  n_hs++;
      if (oa.ls)   n_ls++;
      step(1);
    end
    check_int("a_line_draw_cycles", n_draw, 640);
    check_int("a_line_hsync_cycles", n_hs, 96);
    check_int("a_line_start_per_800", n_ls, 1);
    check_obs("a_line2_start", oa, mk(0, 2, 1, 1, 1, 1, 0));

    // ---------------- B: tiny raster, active-high sync, 3 frames exhaustive ----------------
    rst_b = 1'b1;
    step(2);
    check_obs("b_in_reset", ob, mk(0, 0, 0, 0, 0, 0, 0));
    rst_b = 1'b0;
    step(1);
    mh = 0; mv = 0; n_draw = 0;
    for (int i = 0; i < 3 * 48; i++) begin
      check_obs($sformatf("b_cyc%0d", i), ob, model(mh, mv, 4, 1, 2, 3, 1, 1, 1'b1));
      if (ob.draw) n_draw++;
      if (mh == 7 && mv == 5) begin
        check_int($sformatf("b_frame%0d_draw_count", i / 48), n_draw, 12);
        n_draw = 0;
      end
      mh++;
      if (mh == 8) begin mh = 0; mv = (mv == 5) ? 0 : mv + 1; end
      step(1);
    end

    // ---------------- C: full 525-line frame ----------------
    rst_c = 1'b1;
    step(2);
    rst_c = 1'b0;
    step(1);
    check_obs("c_first_cycle", oc, mk(0, 0, 1, 1, 1, 1, 1));
    mh = 0; mv = 0; mism = 0; n_vs_low = 0; vs_bad = 0; late_draw = 0;
    n_hs_pulse = 0; n_fs = 0; n_draw = 0;
    prev_vs = 1'b1; prev_hs = 1'b1;
    for (int i = 0; i < 8400; i++) begin
      ex = model(mh, mv, 8, 2, 3, 480, 10, 2, 1'b0);
      if (oc !== ex) mism++;
      if (!oc.vs) n_vs_low++;
      if (oc.vs != prev_vs && oc.h != 10'd0) vs_bad++;
      if (oc.draw && oc.v >= 10'd480) late_draw++;
      if (!oc.hs && prev_hs) n_hs_pulse++;
      if (oc.fs) n_fs++;
      if (oc.draw) n_draw++;
      sig1[i] = {oc.hs, oc.vs, oc.draw, oc.ls, oc.fs};
      if (mh == 0 && mv == 101) check_obs("c_wrap_line_100", oc, mk(0, 101, 1, 1, 1, 1, 0));
      prev_vs = oc.vs;
      prev_hs = oc.hs;
      mh++;
      if (mh == 16) begin mh = 0; mv = (mv == 524) ? 0 : mv + 1; end
      step(1);
    end
    check_int("c_frame_model_mismatches", mism, 0);
    check_int("c_vsync_low_cycles", n_vs_low, 32);
    check_int("c_vsync_edge_off_h0", vs_bad, 0);
    check_int("c_draw_in_vblank", late_draw, 0);
    check_int("c_hsync_pulses", n_hs_pulse, 525);
    check_int("c_frame_starts", n_fs, 1);
    check_int("c_draw_cycles", n_draw, 3840);
    check_obs("c_frame_wrap", oc, mk(0, 0, 1, 1, 1, 1, 1));

    // Mid-frame reset, then the next frame must repeat the post-power-up frame.
    step(200 * 16 + 5);
    check_obs("c_pre_reset", oc, mk(5, 200, 1, 1, 1, 0, 0));
    rst_c = 1'b1;
    step(1);
    check_obs("c_mid_reset", oc, mk(0, 0, 1, 1, 0, 0, 0));
    rst_c = 1'b0;
    step(1);
    check_obs("c_after_mid_reset", oc, mk(0, 0, 1, 1, 1, 1, 1));
    mh = 0; mv = 0; mism = 0;
    for (int i = 0; i < 8400; i++) begin
      if ({oc.hs, oc.vs, oc.draw, oc.ls, oc.fs} !== sig1[i]) mism++;
      if (oc.h !== 10'(mh) || oc.v !== 10'(mv)) mism++;
      mh++;
      if (mh == 16) begin mh = 0; mv = (mv == 524) ? 0 : mv + 1; end
      step(1);
    end
    check_int("c_frame_after_reset_repeat", mism, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
